bus_master_port: RTL and testbench



---
 rtl/bus_master_port.sv | 198 +++++++++++++++++++
 tb/tb_bus_master_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// Master-side port: turns a parallel device request into the serial system-bus
// sequence (bus request, device address, memory address, write/read data).
module bus_master_port #(
    parameter int unsigned ADDR_WIDTH        = 16,
    parameter int unsigned DEVICE_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned ACK_TIMEOUT       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derror,
    output logic                  mbreq,
    input  logic                  mbgrant,
    input  logic                  split_grant,
    output logic                  mvalid,
    output logic                  mwdata,
    output logic                  mmode,
    input  logic                  ack,
    input  logic                  sready,
    input  logic                  ssplit,
    input  logic                  svalid,
    input  logic                  srdata
);

    localparam int unsigned MEM_WIDTH = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
    localparam int unsigned MAX_A     = (MEM_WIDTH > DATA_WIDTH) ? MEM_WIDTH : DATA_WIDTH;
    localparam int unsigned MAX_B     = (DEVICE_ADDR_WIDTH > ACK_TIMEOUT) ? DEVICE_ADDR_WIDTH : ACK_TIMEOUT;
    localparam int unsigned MAX_COUNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_COUNT) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_SADDR, S_WAIT_ACK, S_MADDR,
        S_WDATA, S_WRESP, S_RWAIT, S_RDATA, S_SPLIT
    } state_t;

    state_t                       r_state;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic [DEVICE_ADDR_WIDTH-1:0] r_dev_sh;
    logic [MEM_WIDTH-1:0]         r_mem_sh;
    logic [DATA_WIDTH-1:0]        r_wd_sh;
    logic [DATA_WIDTH-1:0]        r_rd_sh;
    logic [DATA_WIDTH-1:0]        w_rd_next;

    // Read word after shifting in the current serial bit (LSB arrives first).
    always_comb begin
        w_rd_next = {srdata, r_rd_sh[DATA_WIDTH-1:1]};
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dev_sh <= '0;
            r_mem_sh <= '0;
            r_wd_sh  <= '0;
            r_rd_sh  <= '0;
            dready   <= 1'b1;
            drdata   <= '0;
            ddone    <= 1'b0;
            derror   <= 1'b0;
            mbreq    <= 1'b0;
            mvalid   <= 1'b0;
            mwdata   <= 1'b0;
            mmode    <= 1'b0;
        end else begin
            ddone  <= 1'b0;
            derror <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dvalid) begin
                        r_dev_sh <= daddr[ADDR_WIDTH-1:MEM_WIDTH];
                        r_mem_sh <= daddr[MEM_WIDTH-1:0];
                        r_wd_sh  <= dwdata;
                        mmode    <= dmode;
                        dready   <= 1'b0;
                        mbreq    <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mbgrant) begin
                        mvalid   <= 1'b1;
                        mwdata   <= r_dev_sh[0];
                        r_dev_sh <= r_dev_sh >> 1;
                        r_cnt    <= '0;
                        r_state  <= S_SADDR;
                    end
                end
                S_SADDR: begin
                    if (r_cnt == CNT_WIDTH'(DEVICE_ADDR_WIDTH - 1)) begin
                        mvalid  <= 1'b0;
                        mwdata  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_ACK;
                    end else begin
                        mwdata   <= r_dev_sh[0];
                        r_dev_sh <= r_dev_sh >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack) begin
                        mvalid   <= 1'b1;
                        mwdata   <= r_mem_sh[0];
                        r_mem_sh <= r_mem_sh >> 1;
                        r_cnt    <= '0;
                        r_state  <= S_MADDR;
                    end else if (r_cnt == CNT_WIDTH'(ACK_TIMEOUT - 1)) begin
                        derror  <= 1'b1;
                        mbreq   <= 1'b0;
                        dready  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MADDR: begin
                    if (r_cnt == CNT_WIDTH'(MEM_WIDTH - 1)) begin
                        r_cnt <= '0;
                        if (mmode) begin
                            mwdata  <= r_wd_sh[0];
                            r_wd_sh <= r_wd_sh >> 1;
                            r_state <= S_WDATA;
                        end else begin
                            mvalid  <= 1'b0;
                            mwdata  <= 1'b0;
                            r_state <= S_RWAIT;
                        end
                    end else begin
                        mwdata   <= r_mem_sh[0];
                        r_mem_sh <= r_mem_sh >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        mvalid  <= 1'b0;
                        mwdata  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WRESP;
                    end else begin
                        mwdata  <= r_wd_sh[0];
                        r_wd_sh <= r_wd_sh >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_WRESP: begin
                    if (sready) begin
                        ddone   <= 1'b1;
                        mbreq   <= 1'b0;
                        dready  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                // Split wins over a same-cycle data bit; the slave resends the whole word.
                S_RWAIT, S_RDATA: begin
                    if (ssplit) begin
                        mbreq   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_SPLIT;
                    end else if (svalid) begin
                        r_rd_sh <= w_rd_next;
                        if (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                            drdata  <= w_rd_next;
                            ddone   <= 1'b1;
                            mbreq   <= 1'b0;
                            dready  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_RDATA;
                        end
                    end
                end
                S_SPLIT: begin
                    if (split_grant) begin
                        mbreq   <= 1'b1;
                        r_state <= S_RWAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: write, read with gap, ack timeout,
// split/resume, reset mid-write and a stray request during a transaction.
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dvalid = 1'b0;
    logic        dready;
    logic        dmode = 1'b0;
    logic [15:0] daddr = '0;
    logic [7:0]  dwdata = '0;
    logic [7:0]  drdata;
    logic        ddone;
    logic        derror;
    logic        mbreq;
    logic        mbgrant = 1'b0;
    logic        split_grant = 1'b0;
    logic        mvalid;
    logic        mwdata;
    logic        mmode;
    logic        ack = 1'b0;
    logic        sready = 1'b0;
    logic        ssplit = 1'b0;
    logic        svalid = 1'b0;
    logic        srdata = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    bus_master_port dut (
        .clk(clk), .rst(rst), .dvalid(dvalid), .dready(dready), .dmode(dmode),
        .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .ddone(ddone),
        .derror(derror), .mbreq(mbreq), .mbgrant(mbgrant),
        .split_grant(split_grant), .mvalid(mvalid), .mwdata(mwdata),
        .mmode(mmode), .ack(ack), .sready(sready), .ssplit(ssplit),
        .svalid(svalid), .srdata(srdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic mode, input logic [15:0] addr, input logic [7:0] wd);
        dmode  = mode;
        daddr  = addr;
        dwdata = wd;
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        chk("req_dready", 32'(dready), 32'd0);
        chk("req_mbreq", 32'(mbreq), 32'd1);
    endtask

    task automatic grant();
        mbgrant = 1'b1;
        tick();
        mbgrant = 1'b0;
    endtask

    task automatic give_ack();
        chk("wait_mvalid", 32'(mvalid), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic send_bits(input string tag, input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_mvalid"}, 32'(mvalid), 32'd1);
            chk(tag, 32'(mwdata), 32'(val[i]));
            tick();
        end
    endtask

    // Slave returns a word LSB first; optional two-cycle svalid gap after bit 3.
    task automatic recv_word(input string tag, input logic [7:0] val, input logic gap);
        for (int i = 0; i < 8; i++) begin
            svalid = 1'b1;
            srdata = val[i];
            tick();
            svalid = 1'b0;
            if (i < 7) chk({tag, "_early_done"}, 32'(ddone), 32'd0);
            if (gap && i == 3) begin
                tick();
                tick();
                chk({tag, "_gap_done"}, 32'(ddone), 32'd0);
            end
        end
        chk({tag, "_ddone"}, 32'(ddone), 32'd1);
        chk({tag, "_drdata"}, 32'(drdata), 32'(val));
        tick();
        chk({tag, "_ddone_pulse"}, 32'(ddone), 32'd0);
        chk({tag, "_drdata_hold"}, 32'(drdata), 32'(val));
        chk({tag, "_dready"}, 32'(dready), 32'd1);
        chk({tag, "_mbreq"}, 32'(mbreq), 32'd0);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dready", 32'(dready), 32'd1);
        chk("rst_mbreq", 32'(mbreq), 32'd0);
        chk("rst_mvalid", 32'(mvalid), 32'd0);
        chk("rst_mwdata", 32'(mwdata), 32'd0);
        chk("rst_drdata", 32'(drdata), 32'd0);
        chk("rst_ddone", 32'(ddone), 32'd0);
        chk("rst_derror", 32'(derror), 32'd0);
        chk("rst_mmode", 32'(mmode), 32'd0);

        // Write 0x1234 / 0xA5, grant two cycles after request
        start_req(1'b1, 16'h1234, 8'hA5);
        chk("w1_mmode", 32'(mmode), 32'd1);
        chk("w1_mvalid_req", 32'(mvalid), 32'd0);
        tick();
        grant();
        send_bits("w1_dev", 32'h1, 4);
        give_ack();
        send_bits("w1_mem", 32'h234, 12);
        send_bits("w1_wd", 32'hA5, 8);
        chk("w1_wresp_mvalid", 32'(mvalid), 32'd0);
        tick();
        tick();
        chk("w1_no_done", 32'(ddone), 32'd0);
        sready = 1'b1;
        tick();
        sready = 1'b0;
        chk("w1_ddone", 32'(ddone), 32'd1);
        chk("w1_dready", 32'(dready), 32'd1);
        chk("w1_mbreq", 32'(mbreq), 32'd0);
        tick();
        chk("w1_ddone_pulse", 32'(ddone), 32'd0);

        // Read 0x2010, slave returns 0x3C with a gap
        start_req(1'b0, 16'h2010, 8'h00);
        chk("r1_mmode", 32'(mmode), 32'd0);
        grant();
        send_bits("r1_dev", 32'h2, 4);
        give_ack();
        send_bits("r1_mem", 32'h010, 12);
        chk("r1_rwait_mvalid", 32'(mvalid), 32'd0);
        recv_word("r1", 8'h3C, 1'b1);

        // Device 0x7 never acked: derror after four wait cycles
        start_req(1'b1, 16'h7ABC, 8'h11);
        grant();
        send_bits("to_dev", 32'h7, 4);
        for (int i = 0; i < 4; i++) begin
            chk("to_derror_early", 32'(derror), 32'd0);
            chk("to_mbreq_held", 32'(mbreq), 32'd1);
            tick();
        end
        chk("to_derror", 32'(derror), 32'd1);
        chk("to_ddone", 32'(ddone), 32'd0);
        chk("to_mbreq", 32'(mbreq), 32'd0);
        chk("to_dready", 32'(dready), 32'd1);
        tick();
        chk("to_derror_pulse", 32'(derror), 32'd0);

        // Read with split in RWAIT (same cycle as a data bit), resume on split_grant only
        start_req(1'b0, 16'h5123, 8'h00);
        grant();
        send_bits("sp_dev", 32'h5, 4);
        give_ack();
        send_bits("sp_mem", 32'h123, 12);
        ssplit = 1'b1;
        svalid = 1'b1;
        srdata = 1'b1;
        tick();
        ssplit = 1'b0;
        svalid = 1'b0;
        chk("sp_mbreq_drop", 32'(mbreq), 32'd0);
        chk("sp_mvalid", 32'(mvalid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            mbgrant = (i == 4);
            tick();
            chk("sp_hold_mbreq", 32'(mbreq), 32'd0);
        end
        mbgrant = 1'b0;
        split_grant = 1'b1;
        tick();
        split_grant = 1'b0;
        chk("sp_resume_mbreq", 32'(mbreq), 32'd1);
        chk("sp_resume_mvalid", 32'(mvalid), 32'd0);
        tick();
        chk("sp_no_resend", 32'(mvalid), 32'd0);
        recv_word("sp", 8'hF0, 1'b0);

        // Reset during write data bit 4
        start_req(1'b1, 16'h1234, 8'hA5);
        grant();
        send_bits("rs_dev", 32'h1, 4);
        give_ack();
        send_bits("rs_mem", 32'h234, 12);
        send_bits("rs_wd", 32'hA5, 4);
        chk("rs_bit4", 32'(mwdata), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_mvalid", 32'(mvalid), 32'd0);
        chk("rs_mbreq", 32'(mbreq), 32'd0);
        chk("rs_dready", 32'(dready), 32'd1);
        chk("rs_ddone", 32'(ddone), 32'd0);
        chk("rs_derror", 32'(derror), 32'd0);
        tick();
        chk("rs_ddone_after", 32'(ddone), 32'd0);
        chk("rs_derror_after", 32'(derror), 32'd0);

        // Write after reset, with a stray request that must be ignored
        start_req(1'b1, 16'h3456, 8'h5A);
        dmode  = 1'b0;
        daddr  = 16'hFFFF;
        dwdata = 8'h00;
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        chk("st_dready", 32'(dready), 32'd0);
        chk("st_mmode", 32'(mmode), 32'd1);
        grant();
        send_bits("st_dev", 32'h3, 4);
        give_ack();
        send_bits("st_mem", 32'h456, 12);
        send_bits("st_wd", 32'h5A, 8);
        sready = 1'b1;
        tick();
        sready = 1'b0;
        chk("st_ddone", 32'(ddone), 32'd1);
        chk("st_dready_end", 32'(dready), 32'd1);
        chk("st_mbreq_end", 32'(mbreq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
